univ_shift_reg_n: RTL and testbench



---
 rtl/univ_shift_reg_n.sv | 117 +++++++++++
 tb/tb_univ_shift_reg_n.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg_n.sv
// Parametrised universal shift register: hold/shift/load/rotate/ashr/clear,
// either as a single enabled step or as a counted burst with busy/done handshake.
module univ_shift_reg_n #(
    parameter int WIDTH = 8,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] q_reg;
    logic [SHW-1:0]   cnt_reg;
    logic [2:0]       mode_lat_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] shr_vec, shl_vec, rotr_vec, rotl_vec, ashr_vec;

    // A running burst uses the mode captured at acceptance, not the live input.
    assign step_mode = (state_reg == RUN) ? mode_lat_reg : mode;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_neighbour
            assign shr_vec[gi]    = q_reg[gi+1];
            assign rotr_vec[gi]   = q_reg[gi+1];
            assign ashr_vec[gi]   = q_reg[gi+1];
            assign shl_vec[gi+1]  = q_reg[gi];
            assign rotl_vec[gi+1] = q_reg[gi];
        end
    endgenerate

    assign shr_vec[WIDTH-1]  = sin_r;
    assign rotr_vec[WIDTH-1] = q_reg[0];
    assign ashr_vec[WIDTH-1] = q_reg[WIDTH-1];
    assign shl_vec[0]        = sin_l;
    assign rotl_vec[0]       = q_reg[WIDTH-1];

    always_comb begin
        step_val = q_reg;
        case (step_mode)
            3'b000:  step_val = q_reg;
            3'b001:  step_val = shr_vec;
            3'b010:  step_val = shl_vec;
            3'b011:  step_val = pin;
            3'b100:  step_val = rotr_vec;
            3'b101:  step_val = rotl_vec;
            3'b110:  step_val = ashr_vec;
            default: step_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            q_reg        <= '0;
            cnt_reg      <= '0;
            mode_lat_reg <= 3'b000;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (shamt != '0)
                            q_reg <= step_val;
                        if (shamt > SHW'(1)) begin
                            mode_lat_reg <= mode;
                            cnt_reg      <= shamt - SHW'(1);
                            state_reg    <= RUN;
                            busy_reg     <= 1'b1;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end else if (en) begin
                        q_reg <= step_val;
                    end
                end
                RUN: begin
                    q_reg   <= step_val;
                    cnt_reg <= cnt_reg - SHW'(1);
                    if (cnt_reg == SHW'(1)) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pout   = q_reg;
    assign sout_r = q_reg[0];
    assign sout_l = q_reg[WIDTH-1];
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Bench for univ_shift_reg_n: directed scenarios then random traffic, all
// checked against an arithmetic step model with a remaining-steps counter.
module tb_univ_shift_reg_n;

    localparam int W = 8;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic         sin_r = 1'b0;
    logic         sin_l = 1'b0;
    logic [W-1:0] pin = '0;
    logic         start = 1'b0;
    logic [S-1:0] shamt = '0;
    logic [W-1:0] pout;
    logic         sout_r, sout_l, busy, done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_q;
    int           m_rem;
    logic [2:0]   m_lat;
    logic         m_done;
    logic         prev_done;

    univ_shift_reg_n #(.WIDTH(W), .SHW(S)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .pin(pin), .start(start), .shamt(shamt), .pout(pout), .sout_r(sout_r),
        .sout_l(sout_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_step(input logic [2:0] md, input logic [W-1:0] q);
        case (md)
            3'd1:    return (q >> 1) | (W'(sin_r) << (W - 1));
            3'd2:    return (q << 1) | W'(sin_l);
            3'd3:    return pin;
            3'd4:    return (q >> 1) | (q << (W - 1));
            3'd5:    return (q << 1) | (q >> (W - 1));
            3'd6:    return W'($signed(q) >>> 1);
            3'd7:    return '0;
            default: return q;
        endcase
    endfunction

    task automatic model_reset();
        m_q = '0; m_rem = 0; m_lat = 3'd0; m_done = 1'b0;
    endtask

    // Expected effect of one rising edge given the currently driven inputs.
    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_q = ref_step(m_lat, m_q);
                m_rem--;
                if (m_rem == 0) m_done = 1'b1;
            end else if (start) begin
                if (int'(shamt) == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_q = ref_step(mode, m_q);
                    if (int'(shamt) == 1) m_done = 1'b1;
                    else begin
                        m_rem = int'(shamt) - 1;
                        m_lat = mode;
                    end
                end
            end else if (en) begin
                m_q = ref_step(mode, m_q);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"}, pout, m_q);
        chk({tag, ".sout_r"}, W'(sout_r), W'(m_q[0]));
        chk({tag, ".sout_l"}, W'(sout_l), W'(m_q[W-1]));
        chk({tag, ".busy"}, W'(busy), W'(m_rem > 0));
        chk({tag, ".done"}, W'(done), W'(m_done));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
        $display("step %-10s mode=%0d en=%b start=%b shamt=%0d q=%h busy=%b done=%b",
                 tag, mode, en, start, shamt, pout, busy, done);
    endtask

    task automatic idle_inputs();
        en = 1'b0; start = 1'b0; mode = 3'd0;
    endtask

    task automatic load_q(input logic [W-1:0] v);
        idle_inputs(); en = 1'b1; mode = 3'd3; pin = v;
        tick("load");
        idle_inputs();
    endtask

    initial begin
        model_reset();
        tick("reset");
        tick("reset");
        rst = 1'b0;
        tick("idle");

        // Single steps with the live mode
        load_q(8'hA5);
        chk("ld_a5", pout, 8'hA5);
        en = 1'b1; mode = 3'd1; sin_r = 1'b1;
        tick("shr");
        chk("shr_d2", pout, 8'hD2);
        chk("shr_sout_r", W'(sout_r), W'(0));
        mode = 3'd2; sin_l = 1'b0;
        tick("shl");
        chk("shl_a4", pout, 8'hA4);

        // Burst rotr by 3; live en/mode changes during the burst must not matter
        load_q(8'h81);
        start = 1'b1; mode = 3'd4; shamt = 4'd3;
        tick("rotr_k");
        start = 1'b0; en = 1'b1; mode = 3'd7;
        chk("rotr_busy_k", W'(busy), W'(1));
        tick("rotr_k1");
        chk("rotr_busy_k1", W'(busy), W'(1));
        tick("rotr_k2");
        chk("rotr_30", pout, 8'h30);
        chk("rotr_done", W'(done), W'(1));
        idle_inputs();
        tick("rotr_post");
        chk("rotr_done_off", W'(done), W'(0));

        // ashr saturates, rotl wraps modulo width
        load_q(8'h80);
        start = 1'b1; mode = 3'd6; shamt = 4'd15;
        tick("ashr_k");
        idle_inputs();
        for (int i = 0; i < 14; i++) tick("ashr_run");
        chk("ashr_ff", pout, 8'hFF);
        chk("ashr_done", W'(done), W'(1));
        load_q(8'h01);
        start = 1'b1; mode = 3'd5; shamt = 4'd9;
        tick("rotl_k");
        idle_inputs();
        for (int i = 0; i < 8; i++) tick("rotl_run");
        chk("rotl_02", pout, 8'h02);

        // shamt boundaries 0 and 1
        load_q(8'h3C);
        start = 1'b1; mode = 3'd4; shamt = 4'd0;
        tick("sh0");
        chk("sh0_q", pout, 8'h3C);
        chk("sh0_busy", W'(busy), W'(0));
        chk("sh0_done", W'(done), W'(1));
        shamt = 4'd1;
        tick("sh1");
        chk("sh1_q", pout, 8'h1E);
        chk("sh1_busy", W'(busy), W'(0));
        idle_inputs();
        tick("sh1_post");

        // start held high: back-to-back bursts, done never two cycles long
        start = 1'b1; mode = 3'd5; shamt = 4'd2;
        prev_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick("b2b");
            if (prev_done) chk("b2b_single_done", W'(done), W'(0));
            prev_done = done;
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) tick("b2b_tail");

        // start beats en in IDLE
        load_q(8'h5A);
        start = 1'b1; en = 1'b1; mode = 3'd7; shamt = 4'd2; pin = 8'hEE;
        tick("prio_k");
        idle_inputs();
        chk("prio_busy", W'(busy), W'(1));
        tick("prio_k1");
        chk("prio_zero", pout, 8'h00);
        chk("prio_done", W'(done), W'(1));
        tick("prio_post");

        // Asynchronous reset mid-burst
        load_q(8'h0F);
        start = 1'b1; mode = 3'd5; shamt = 4'd6;
        tick("abort_k");
        idle_inputs();
        tick("abort_k1");
        rst = 1'b1;
        #1;
        model_reset();
        chk("abort_q", pout, 8'h00);
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_done", W'(done), W'(0));
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) tick("abort_idle");
        load_q(8'h0F);
        start = 1'b1; mode = 3'd5; shamt = 4'd6;
        tick("again_k");
        idle_inputs();
        for (int i = 0; i < 5; i++) tick("again_run");
        chk("again_q", pout, 8'hC3);
        chk("again_done", W'(done), W'(1));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 3) == 0);
            en    = $urandom_range(0, 1);
            mode  = 3'($urandom_range(0, 7));
            shamt = S'($urandom_range(0, 15));
            sin_r = $urandom_range(0, 1);
            sin_l = $urandom_range(0, 1);
            pin   = W'($urandom);
            tick("rand");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
